lcd_frame_streamer: RTL

// - Upstream feeder of the LT24 LCD driver: rasterises one full LCD frame, pixel by pixel, into the driver's pixel_rgb/print/done handshake.
// - Pixels inside a scaled CANVASxCANVAS 1-bit drawing canvas (the handwritten-digit pad) take FG_COLOR if the canvas bit is set, else BG_COLOR.
// - Pixels outside the canvas window take BG_COLOR.
// - The canvas is read through a synchronous 1-cycle-latency RAM port.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_raster_counter.sv | 149 ++++++++++++++
 rtl/lcd_frame_streamer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LT24 LCD frame path.
package lcd_pkg;

    // RGB565 pixel
    localparam int unsigned RgbWidth = 16;
    typedef logic [RgbWidth-1:0] rgb565_t;

    // LT24 panel geometry (portrait)
    localparam int unsigned Lt24Width  = 240;
    localparam int unsigned Lt24Height = 320;

    localparam rgb565_t ColorWhite = 16'hFFFF;
    localparam rgb565_t ColorBlack = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StPixel,
        StFetch,
        StWaitDone,
        StAdvance
    } lcd_state_e;

    // Counter width that never collapses to zero bits for tiny ranges
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_raster_counter.sv
// Raster scan position plus canvas-cell tracking for the drawing window.
// Cells are followed with sub-counters so no divide/multiply is needed on x/y.
module lcd_raster_counter
    import lcd_pkg::*;
#(
    parameter int unsigned LCD_W  = Lt24Width,
    parameter int unsigned LCD_H  = Lt24Height,
    parameter int unsigned CANVAS = 28,
    parameter int unsigned SCALE  = 8,
    parameter int unsigned X0     = 8,
    parameter int unsigned Y0     = 48,
    localparam int unsigned AW    = clog2_min1(CANVAS * CANVAS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          step,
    output logic          in_window,
    output logic          last_pixel,
    output logic [AW-1:0] cell_addr
);

    localparam int unsigned XW = clog2_min1(LCD_W);
    localparam int unsigned YW = clog2_min1(LCD_H);
    localparam int unsigned CW = clog2_min1(CANVAS);
    localparam int unsigned SW = clog2_min1(SCALE);

    localparam logic [XW-1:0] XLast = XW'(LCD_W - 1);
    localparam logic [YW-1:0] YLast = YW'(LCD_H - 1);
    localparam logic [CW-1:0] CLast = CW'(CANVAS - 1);
    localparam logic [SW-1:0] SLast = SW'(SCALE - 1);
    // Column/row just before the window; stepping off it enters the window
    localparam logic [XW-1:0] XPre  = XW'(X0 - 1);
    localparam logic [YW-1:0] YPre  = YW'(Y0 - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [AW-1:0] row_base_q, row_base_d;  // cy*CANVAS, kept by accumulation
    logic          in_x_q, in_x_d, in_y_q, in_y_d;

    // Next scan position and window-relative cell coordinates
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        row_base_d = row_base_q;
        in_x_d     = in_x_q;
        in_y_d     = in_y_q;
        if (clear) begin
            x_d        = '0;
            y_d        = '0;
            sx_d       = '0;
            sy_d       = '0;
            cx_d       = '0;
            cy_d       = '0;
            row_base_d = '0;
            in_x_d     = (X0 == 0);
            in_y_d     = (Y0 == 0);
        end else if (step) begin
            if (x_q == XLast) begin
                // New row: horizontal tracking restarts
                x_d    = '0;
                sx_d   = '0;
                cx_d   = '0;
                in_x_d = (X0 == 0);
                if (y_q == YLast) begin
                    y_d        = '0;
                    sy_d       = '0;
                    cy_d       = '0;
                    row_base_d = '0;
                    in_y_d     = (Y0 == 0);
                end else begin
                    y_d = y_q + 1'b1;
                    if ((Y0 != 0) && (y_q == YPre)) begin
                        in_y_d     = 1'b1;
                        sy_d       = '0;
                        cy_d       = '0;
                        row_base_d = '0;
                    end else if (in_y_q) begin
                        if (sy_q == SLast) begin
                            sy_d = '0;
                            if (cy_q == CLast) begin
                                in_y_d = 1'b0;
                            end else begin
                                cy_d       = cy_q + 1'b1;
                                row_base_d = row_base_q + AW'(CANVAS);
                            end
                        end else begin
                            sy_d = sy_q + 1'b1;
                        end
                    end
                end
            end else begin
                x_d = x_q + 1'b1;
                if ((X0 != 0) && (x_q == XPre)) begin
                    in_x_d = 1'b1;
                    sx_d   = '0;
                    cx_d   = '0;
                end else if (in_x_q) begin
                    if (sx_q == SLast) begin
                        sx_d = '0;
                        if (cx_q == CLast) begin
                            in_x_d = 1'b0;
                        end else begin
                            cx_d = cx_q + 1'b1;
                        end
                    end else begin
                        sx_d = sx_q + 1'b1;
                    end
                end
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            row_base_q <= '0;
            in_x_q     <= 1'b0;
            in_y_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            row_base_q <= row_base_d;
            in_x_q     <= in_x_d;
            in_y_q     <= in_y_d;
        end
    end

    assign in_window  = in_x_q & in_y_q;
    assign last_pixel = (x_q == XLast) && (y_q == YLast);
    assign cell_addr  = row_base_q + AW'(cx_q);

endmodule

// File: rtl/lcd_frame_streamer.sv
// Streams one full LCD frame into the LT24 driver's pixel/print/done handshake,
// colouring pixels inside the scaled canvas window from a 1-bit canvas RAM.
module lcd_frame_streamer
    import lcd_pkg::*;
#(
    parameter int unsigned LCD_W    = Lt24Width,
    parameter int unsigned LCD_H    = Lt24Height,
    parameter int unsigned CANVAS   = 28,
    parameter int unsigned SCALE    = 8,
    parameter int unsigned X0       = 8,
    parameter int unsigned Y0       = 48,
    parameter rgb565_t     FG_COLOR = ColorWhite,
    parameter rgb565_t     BG_COLOR = ColorBlack,
    localparam int unsigned AW      = clog2_min1(CANVAS * CANVAS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                lcd_initialized,
    input  logic                refresh,
    output logic [RgbWidth-1:0] pixel_rgb,
    output logic                print,
    input  logic                lcd_done,
    output logic                canvas_rd,
    output logic [AW-1:0]       canvas_addr,
    input  logic                canvas_data,
    output logic                busy,
    output logic                frame_done
);

    lcd_state_e    state_q, state_d;
    logic          pending_q, pending_d;
    rgb565_t       rgb_q, rgb_d;
    logic          print_q, print_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          cnt_clear, cnt_step;
    logic          in_window, last_pixel;
    logic [AW-1:0] cell_addr;

    lcd_raster_counter #(
        .LCD_W  (LCD_W),
        .LCD_H  (LCD_H),
        .CANVAS (CANVAS),
        .SCALE  (SCALE),
        .X0     (X0),
        .Y0     (Y0)
    ) u_raster (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .step       (cnt_step),
        .in_window  (in_window),
        .last_pixel (last_pixel),
        .cell_addr  (cell_addr)
    );

    // Next-state and output decode; with en low every register holds
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        rgb_d     = rgb_q;
        print_d   = print_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = en ? 1'b0 : done_q;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    // busy stays up through the frame_done cycle, drops after
                    busy_d = 1'b0;
                    if (pending_q && lcd_initialized) begin
                        state_d   = StPixel;
                        busy_d    = 1'b1;
                        pending_d = 1'b0;
                        cnt_clear = 1'b1;
                    end
                end
                StPixel: begin
                    if (in_window) begin
                        addr_d  = cell_addr;
                        state_d = StFetch;
                    end else begin
                        rgb_d   = BG_COLOR;
                        print_d = 1'b1;
                        state_d = StWaitDone;
                    end
                end
                StFetch: begin
                    rgb_d   = canvas_data ? FG_COLOR : BG_COLOR;
                    print_d = 1'b1;
                    state_d = StWaitDone;
                end
                StWaitDone: begin
                    if (lcd_done) begin
                        print_d = 1'b0;
                        state_d = StAdvance;
                    end
                end
                StAdvance: begin
                    cnt_step = 1'b1;
                    if (last_pixel) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StPixel;
                    end
                end
                default: state_d = StIdle;
            endcase
            // A request is never lost, even one landing on a frame start
            if (refresh) begin
                pending_d = 1'b1;
            end
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            rgb_q     <= '0;
            print_q   <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rgb_q     <= rgb_d;
            print_q   <= print_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Read is issued in PIXEL so the RAM answers in time for FETCH
    assign canvas_rd   = (state_q == StPixel) && in_window;
    assign canvas_addr = canvas_rd ? cell_addr : addr_q;
    assign pixel_rgb   = rgb_q;
    assign print       = print_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule
